// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: handshake bundle between N producers, the arbiter and one consumer
interface rr_stream_mux_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N)
);
  logic                 mode;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  modport master (output mode, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
  modport slave  (input mode, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream mux, fixed-priority or round-robin arbiter, registered output
module rr_stream_mux #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_stream_mux_if.slave  bus
);
  logic [SELW-1:0]  ptr_q, ptr_d, g, idx;
  logic             any, load, xfer;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  int               j;
  // Walk the search order backwards so the first valid channel in order is the last one written
  always_comb begin
    g   = '0;
    any = 1'b0;
    j   = 0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = bus.mode ? int'(ptr_q) + k : k;
      if (j >= N) j = j - N;
      idx = SELW'(j);
      if (bus.in_valid[idx]) begin
        g   = idx;
        any = 1'b1;
      end
    end
  end
  assign load         = ~valid_q | bus.out_ready;
  assign xfer         = load & any & rst_n;
  assign bus.in_ready = xfer ? (N'(1) << g) : '0;
  always_comb begin
    ptr_d   = xfer ? ((g == SELW'(N - 1)) ? '0 : g + 1'b1) : ptr_q;
    valid_d = xfer | (valid_q & ~bus.out_ready);
    data_d  = xfer ? bus.in_data[g*WIDTH +: WIDTH] : data_q;
    sel_d   = xfer ? g : sel_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed and random checks of rr_stream_mux against a behavioural arbiter model
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  always #5 clk = ~clk;
  rr_stream_mux_if #(.N(N), .WIDTH(W)) b4 ();
  rr_stream_mux_if #(.N(3), .WIDTH(W)) b3 ();
  rr_stream_mux #(.N(N), .WIDTH(W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  rr_stream_mux #(.N(3), .WIDTH(W)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));
  logic [W-1:0] d [N];
  assign b4.in_data = {d[3], d[2], d[1], d[0]};
  assign b3.in_data = {32'hC2, 32'hC1, 32'hC0};
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  logic m_ov = 1'b0;
  logic [W-1:0] m_od = '0;
  int m_os = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int winner(input logic [N-1:0] v, input logic md, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = md ? (p + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction
  // One clock of the 4-channel DUT: check in_ready before the edge, outputs just after it
  task automatic cyc(output int taken);
    int w;
    logic ld;
    logic [N-1:0] er;
    w = winner(b4.in_valid, b4.mode, m_ptr);
    ld = !m_ov || b4.out_ready;
    er = (rst_n && ld && w >= 0) ? N'(1) << w : '0;
    taken = (rst_n && ld && w >= 0) ? w : -1;
    #1 chk("in_ready", 64'(b4.in_ready), 64'(er));
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
    end else if (taken >= 0) begin
      m_ov = 1'b1; m_od = d[taken]; m_os = taken; m_ptr = (taken + 1) % N;
    end else if (b4.out_ready) m_ov = 1'b0;
    #1;
    chk("out_valid", 64'(b4.out_valid), 64'(m_ov));
    chk("out_data", 64'(b4.out_data), 64'(m_od));
    chk("out_sel", 64'(b4.out_sel), 64'(m_os));
    @(negedge clk);
  endtask
  initial begin
    int t;
    b4.mode = 1'b0; b4.in_valid = '1; b4.out_ready = 1'b0;
    b3.mode = 1'b1; b3.in_valid = '0; b3.out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = 32'h0;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(b4.in_ready), 64'h0);
    chk("rst_out_valid", 64'(b4.out_valid), 64'h0);
    chk("rst_out_data", 64'(b4.out_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; b4.out_ready = 1'b1;
    cyc(t);
    chk("rel_out_sel", 64'(b4.out_sel), 64'h0);
    b4.in_valid = 4'b1010; d[1] = 32'h11; d[3] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      cyc(t);
      chk("fix_data", 64'(b4.out_data), 64'h11);
    end
    b4.in_valid = 4'b1000;
    cyc(t);
    chk("fix_drop_data", 64'(b4.out_data), 64'h33);
    chk("fix_drop_sel", 64'(b4.out_sel), 64'h3);
    b4.mode = 1'b1; b4.in_valid = '1;
    for (int i = 0; i < N; i++) d[i] = 32'hA0 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      cyc(t);
      chk("rr_sel", 64'(b4.out_sel), 64'(k % 4));
      chk("rr_data", 64'(b4.out_data), 64'hA0 + 64'(k % 4));
    end
    b4.in_valid = 4'b0100;
    cyc(t);
    b4.in_valid = 4'b0011;
    cyc(t); chk("wrap_0", 64'(b4.out_sel), 64'h0);
    cyc(t); chk("skip_1", 64'(b4.out_sel), 64'h1);
    cyc(t); chk("wrap_0b", 64'(b4.out_sel), 64'h0);
    b4.in_valid = 4'b0001; d[0] = 32'h55;
    cyc(t);
    b4.in_valid = 4'b0100; d[2] = 32'h77; b4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(t);
      chk("bp_hold", 64'(b4.out_data), 64'h55);
    end
    b4.out_ready = 1'b1;
    cyc(t);
    chk("bp_release", 64'(b4.out_data), 64'h77);
    rst3_n = 1'b1; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("n3_first", 64'(b3.out_sel), 64'h0);
    @(negedge clk);
    b3.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("n3_stall_valid", 64'(b3.out_valid), 64'h1);
    chk("n3_stall_sel", 64'(b3.out_sel), 64'h0);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("n3_rst_valid", 64'(b3.out_valid), 64'h0);
    chk("n3_rst_ready", 64'(b3.in_ready), 64'h0);
    @(negedge clk);
    rst3_n = 1'b1; b3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("n3_sel", 64'(b3.out_sel), 64'(k % 3));
      chk("n3_data", 64'(b3.out_data), 64'hC0 + 64'(k % 3));
      @(negedge clk);
    end
    // Random traffic: sources keep valid/data stable until their own transfer
    b4.in_valid = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) b4.mode = ~b4.mode;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!b4.in_valid[i] && $urandom_range(0, 1) == 1) begin
          b4.in_valid[i] = 1'b1;
          d[i] = $urandom;
        end
      cyc(t);
      if (t >= 0) b4.in_valid[t] = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes and a registered output stage. It is the arbitrated, clocked successor to the 32-bit `twoto1mux` combinational selector. Instead of an external `sel`, an internal arbiter chooses among requesting channels, either by fixed priority or by round-robin. It sits wherever several producers share one consumer bus, such as register-file write-back or a shared memory port.

## Interface
- `N`, default 4: number of input channels, N ≥ 2.
- `WIDTH`, default 32: data width per channel.
- `SELW`, default `$clog2(N)`: width of the grant index. Derived; do not override.

- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset, asynchronous assert, active-low. One clock domain only.
- `mode` input, 1: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `in_valid` input, N: per-channel request.
- `in_data` input, N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_ready` output, N: per-channel accept. It is one-hot or all-zero.
- `out_valid` output, 1: output register holds a word.
- `out_data` output, WIDTH: registered data.
- `out_sel` output, SELW: index of the channel that produced `out_data`.
- `out_ready` input, 1: consumer accepts.

## Operation
- **Output stage.** The output stage is one register: `out_valid`, `out_data`, `out_sel`.
  - `load = ~out_valid | out_ready`.
  - `in_ready[i] = load & grant[i]`.
  - A channel is transferred when `in_valid[i] & in_ready[i]`.
- **Grant.** Grant is combinational from `in_valid`, `mode` and `ptr`. At most one bit is set. It is all-zero if no channel is valid.
  - **mode=0:** grant goes to the lowest index i with `in_valid[i]`.
  - **mode=1:** search i = ptr, ptr+1, … N-1, 0, … ptr-1, with wrap modulo N. The first valid channel wins.
- **Pointer update.**
  - `ptr` has SELW bits. It updates only on a transfer, in either mode.
  - The update is `ptr <= (g == N-1) ? 0 : g+1`, where g is the granted index.
  - When N is not a power of two, `ptr` never holds a value ≥ N.
- **Output register update on each clock edge:**
  - transfer occurs: `out_valid<=1`, `out_data<=in_data[g]`, `out_sel<=g`.
  - no transfer and `out_ready=1`: `out_valid<=0`, `out_data`/`out_sel` hold.
  - otherwise: all hold. Stall holds data stable.
- **Simultaneous drain and fill** (`out_valid & out_ready` and a transfer in the same cycle): the new word replaces the old one. No bubble; throughput is 1 word/cycle.
- **`mode` changes** take effect on the next grant evaluation. `ptr` is kept and is not reset.
- **Protocol rule for sources:** once `in_valid[i]` is asserted it stays high with stable data until transferred. `in_ready` may depend on `in_valid`; `in_valid` must not depend on `in_ready`.

## Timing
- **Reset** (`rst_n=0`, takes effect immediately, asynchronous):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready` is all-zero while `rst_n=0`.
- **Release:** the first transfer is possible on the first rising edge with `rst_n=1`.
- **Latency:** input accepted at edge k appears on `out_data` with `out_valid=1` after edge k, i.e. 1 cycle.
- **Combinational paths:**
  - `in_valid` → `in_ready`.
  - `out_ready` → `in_ready`.
  - No combinational path from any input to `out_valid`, `out_data` or `out_sel`.
- **Reset during a stall:** the held word is discarded. `in_ready` is 0 during reset, so no transfer is lost silently from the source's view.
- **Fairness:** in mode=1, with all N channels continuously valid and `out_ready=1`, grants follow 0,1,…,N-1,0,… Each channel gets exactly one grant per N cycles.

## Test plan
- **Reset:** hold `rst_n=0` with all `in_valid=1`. Expect `in_ready=0000`, `out_valid=0`, `out_data=0`. Deassert `rst_n`; the next edge yields `out_sel=0`.
- **Fixed priority:** `mode=0`, `in_valid=1010`, data ch1=0x11, ch3=0x33, `out_ready=1`. Expect ch1 granted every cycle and `out_data=0x11` each cycle. Drop ch1 valid; the next output is 0x33 with `out_sel=3`.
- **Round-robin fairness:** `mode=1`, all valid, ch i data = 0xA0+i, `out_ready=1` for 8 cycles. Expect `out_sel` sequence 0,1,2,3,0,1,2,3 and matching data.
- **Round-robin skip and wrap:** `mode=1` with `ptr=3` (after a grant to ch2), `in_valid=0011`. Expect a grant to ch0, then ch1, then ch0.
- **Backpressure:** `out_valid=1` holding 0x55 and `out_ready=0` for 3 cycles while ch2 is valid. Expect `in_ready=0000` and `out_data=0x55` stable. Raise `out_ready`; the same edge loads ch2 data, with no bubble.
- **Mid-stall reset and odd N:** with `N=3`, `mode=1`, hit `rst_n=0` mid-stall. Expect `out_valid` to clear immediately. Then stream continuously: `ptr` wraps 2→0 and the grant order is 0,1,2,0.
